clk_freq_meter: RTL and testbench
=================================

# clk_freq_meter

Measures the period of a slow, asynchronous clock or tick (e.g. a derived 1 kHz clock) in cycles of the 100 MHz system clock. It reports each complete period, asserts lock after a run of in-tolerance periods, and flags a fault when the monitored signal stops toggling. It is the checking end of the clock-generation path: generated clocks are fed back here for bring-up and run-time supervision.

## Interface
- PERIOD_W, 20: width of the period counter and the `period` output.
- EXP_PERIOD, 100000: expected period in clk_in_100M cycles.
- TOL, 100: allowed deviation; a period is good iff EXP_PERIOD-TOL <= period <= EXP_PERIOD+TOL.
- LOCK_CNT, 4: number of consecutive good periods required for lock (1..15).
- TIMEOUT, 200000: cycles without a rising edge before a fault is raised; must be > EXP_PERIOD+TOL and < 2^PERIOD_W.
- clk_in_100M  input  1  system clock; all logic is on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- mon_in  input  1  monitored signal, asynchronous to clk_in_100M.
- period  output  PERIOD_W  last measured period, in cycles.
- period_valid  output  1  one-cycle pulse when `period` is updated.
- locked  output  1  LOCK_CNT consecutive good periods seen, with no bad period since.
- fault  output  1  no rising edge on mon_in for TIMEOUT cycles.

## Operation
- Input path: 2-FF synchronizer (sync1, sync2) plus a delay register prev; rise = sync2 & ~prev. Only rising edges are used; duty cycle is ignored.
- cnt (PERIOD_W bits): increments every cycle and saturates at all-ones. On rise, cnt <= 1. For a steady period of P cycles, the cnt value sampled at a rise equals P.
- FSM states:
  - WAIT: entered from reset and on timeout. On rise: go to TRACK. No period is reported, because a partial period is discarded.
  - TRACK: on rise, period <= cnt and period_valid <= 1. A good period increments good_cnt; a bad period clears good_cnt to 0. When good_cnt reaches LOCK_CNT, go to LOCK and set locked.
  - LOCK: on rise, period <= cnt and period_valid <= 1. A bad period clears locked and good_cnt and returns to TRACK. A good period stays in LOCK, with good_cnt saturating at LOCK_CNT.
- Timeout (any state): when cnt == TIMEOUT and no rise occurs in the same cycle:
  - fault <= 1, locked <= 0, good_cnt <= 0, state <= WAIT.
  - cnt keeps counting up to saturation.
- fault clears on the next rise. That rise is handled as WAIT -> TRACK and produces no period_valid.
- Simultaneous rise and cnt == TIMEOUT: rise wins; the period is reported and compared normally, and no fault is raised.
- Saturated cnt at a rise can only happen in WAIT, where it is discarded.
- Comparison uses unsigned PERIOD_W-bit values. The window bounds are computed from the parameters at elaboration time, with no runtime arithmetic overflow.

## Timing
- Reset values:
  - Outputs: period = 0, period_valid = 0, locked = 0, fault = 0.
  - Internal: sync1 = sync2 = prev = 0, cnt = 0, good_cnt = 0, state = WAIT.
- Reset mid-measurement discards all state immediately (asynchronous). The first rise after release is treated as a WAIT-state edge.
- Latency: if clock edge k is the first to sample mon_in high, then period, period_valid, locked and state update at edge k+2.
- locked asserts in the same cycle as the period_valid of the LOCK_CNT-th good period. locked deasserts in the same cycle as the period_valid of a bad period.
- fault asserts on the edge where cnt == TIMEOUT is registered. It clears 2 edges after mon_in is first sampled high.
- mon_in high or low pulses shorter than one clk_in_100M period may be missed; this is acceptable.
- period_valid is never high for two consecutive cycles.

## Test plan
- Reset: hold rst_n = 0 with mon_in toggling -> all outputs 0. Release -> no period_valid before the second rise of mon_in.
- Steady 100000-cycle square wave -> first period_valid with period = 100000 at the 2nd rise. locked = 1 at the 5th rise (4 good periods). fault stays 0.
- Tolerance boundaries while locked: periods 99900 and 100100 -> locked stays 1. Period 100101 -> period_valid with period = 100101 and locked = 0 in the same cycle. Then 4 periods of 100000 -> locked = 1 again.
- Stop mon_in while locked -> fault = 1 and locked = 0 exactly 200000 cycles after the last rise was registered. Restart toggling -> fault clears on the first rise with no period_valid; the following rise gives period_valid.
- Reset asserted 50000 cycles into a locked period -> outputs return to 0 immediately. After release, the steady wave relocks on the 5th rise.
- Rise coincident with cnt == TIMEOUT (period = 200000) -> period_valid with period = 200000, fault stays 0, and the period is counted as bad.

Source files
------------

// File: rtl/clk_freq_meter_if.sv
// clk_freq_meter_if
//   Bundles the monitored input and the measurement results of clk_freq_meter.
//   master : the meter (samples mon_in, drives the results)
//   slave  : the supervising logic (drives mon_in, reads the results)
//   Signals:
//     mon_in        monitored slow clock / tick, asynchronous to the system clock
//     period        last measured period in system-clock cycles
//     period_valid  one-cycle pulse when period is updated
//     locked        run of consecutive in-tolerance periods seen
//     fault         monitored signal has stopped toggling
interface clk_freq_meter_if #(
    parameter int unsigned PERIOD_W = 20
);
    logic                mon_in;
    logic [PERIOD_W-1:0] period;
    logic                period_valid;
    logic                locked;
    logic                fault;

    modport master (
        input  mon_in,
        output period,
        output period_valid,
        output locked,
        output fault
    );

    modport slave (
        output mon_in,
        input  period,
        input  period_valid,
        input  locked,
        input  fault
    );
endinterface

// File: rtl/clk_freq_meter.sv
// clk_freq_meter
//   Measures the period of a slow asynchronous clock/tick in clk_in_100M cycles,
//   reports every complete period, asserts lock after LOCK_CNT consecutive
//   in-tolerance periods and raises a fault when the input stops toggling.
//   Ports:
//     clk_in_100M  system clock, all logic on its rising edge
//     rst_n        asynchronous active-low reset
//     bus          clk_freq_meter_if.master (mon_in in; period, period_valid,
//                  locked, fault out)
module clk_freq_meter #(
    parameter int unsigned PERIOD_W   = 20,
    parameter int unsigned EXP_PERIOD = 100000,
    parameter int unsigned TOL        = 100,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned TIMEOUT    = 200000
) (
    input  logic              clk_in_100M,
    input  logic              rst_n,
    clk_freq_meter_if.master  bus
);
    typedef longint unsigned u64_t;

    // Window bounds are resolved at elaboration in 64 bits so that
    // EXP_PERIOD +/- TOL can neither wrap nor underflow.
    localparam u64_t LO_L  = (EXP_PERIOD > TOL) ? u64_t'(EXP_PERIOD) - u64_t'(TOL) : u64_t'(0);
    localparam u64_t HI_L  = u64_t'(EXP_PERIOD) + u64_t'(TOL);
    localparam u64_t MAX_L = (u64_t'(1) << PERIOD_W) - u64_t'(1);

    localparam logic [PERIOD_W-1:0] WIN_LO    = (LO_L > MAX_L) ? {PERIOD_W{1'b1}} : PERIOD_W'(LO_L);
    localparam logic [PERIOD_W-1:0] WIN_HI    = (HI_L > MAX_L) ? {PERIOD_W{1'b1}} : PERIOD_W'(HI_L);
    localparam logic [PERIOD_W-1:0] TIMEOUT_V = PERIOD_W'(TIMEOUT);
    localparam logic [3:0]          LOCK_V    = 4'(LOCK_CNT);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_TRACK,
        ST_LOCK
    } state_t;

    state_t              state, state_nxt;
    logic                sync1, sync2, prev;
    logic                rise;
    logic [PERIOD_W-1:0] cnt;
    logic [3:0]          good_cnt, good_nxt;
    logic [PERIOD_W-1:0] period_q, period_nxt;
    logic                valid_q, valid_nxt;
    logic                locked_q, locked_nxt;
    logic                fault_q, fault_nxt;
    logic                in_win;
    logic                timeout;

    assign rise    = sync2 & ~prev;
    assign in_win  = (cnt >= WIN_LO) && (cnt <= WIN_HI);
    // A rise in the same cycle as the timeout value takes precedence.
    assign timeout = (cnt == TIMEOUT_V) && !rise;

    // Synchronizer, edge detector and free-running period counter.
    always_ff @(posedge clk_in_100M or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= bus.mon_in;
            sync2 <= sync1;
            prev  <= sync2;
            if (rise)
                cnt <= PERIOD_W'(1);
            else if (cnt != '1)
                cnt <= cnt + 1'b1;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk_in_100M or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_WAIT;
            good_cnt <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
            period_q <= period_nxt;
            valid_q  <= valid_nxt;
            locked_q <= locked_nxt;
            fault_q  <= fault_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        if (rise) begin
            unique case (state)
                ST_WAIT:  state_nxt = ST_TRACK;
                ST_TRACK: if (in_win && (good_cnt == LOCK_V - 4'd1)) state_nxt = ST_LOCK;
                ST_LOCK:  if (!in_win) state_nxt = ST_TRACK;
                default:  state_nxt = ST_WAIT;
            endcase
        end else if (timeout) begin
            state_nxt = ST_WAIT;
        end
    end

    // Output / datapath next values.
    always_comb begin
        period_nxt = period_q;
        valid_nxt  = 1'b0;
        locked_nxt = locked_q;
        good_nxt   = good_cnt;
        fault_nxt  = fault_q;
        if (rise) begin
            fault_nxt = 1'b0;
            unique case (state)
                ST_WAIT: begin
                    // Partial period since reset/timeout: discarded.
                end
                ST_TRACK: begin
                    period_nxt = cnt;
                    valid_nxt  = 1'b1;
                    if (!in_win) begin
                        good_nxt = '0;
                    end else if (good_cnt == LOCK_V - 4'd1) begin
                        good_nxt   = LOCK_V;
                        locked_nxt = 1'b1;
                    end else begin
                        good_nxt = good_cnt + 4'd1;
                    end
                end
                ST_LOCK: begin
                    period_nxt = cnt;
                    valid_nxt  = 1'b1;
                    if (!in_win) begin
                        good_nxt   = '0;
                        locked_nxt = 1'b0;
                    end
                end
                default: begin
                    good_nxt   = '0;
                    locked_nxt = 1'b0;
                end
            endcase
        end else if (timeout) begin
            fault_nxt  = 1'b1;
            locked_nxt = 1'b0;
            good_nxt   = '0;
        end
    end

    assign bus.period       = period_q;
    assign bus.period_valid = valid_q;
    assign bus.locked       = locked_q;
    assign bus.fault        = fault_q;
endmodule

// File: tb/tb_clk_freq_meter.sv
// tb_clk_freq_meter
//   Directed bench for clk_freq_meter. Parameters are scaled down
//   (EXP_PERIOD 100, TOL 10, LOCK_CNT 4, TIMEOUT 200) to keep the run short;
//   the scenarios mirror the full-size behaviour one for one.
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_clk_freq_meter;
    logic clk_in_100M = 1'b0;
    logic rst_n       = 1'b1;

    int checks = 0;
    int errors = 0;

    logic lock_exp  = 1'b0;
    logic fault_exp = 1'b0;

    clk_freq_meter_if #(.PERIOD_W(20)) bus ();

    clk_freq_meter #(
        .PERIOD_W  (20),
        .EXP_PERIOD(100),
        .TOL       (10),
        .LOCK_CNT  (4),
        .TIMEOUT   (200)
    ) dut (
        .clk_in_100M(clk_in_100M),
        .rst_n      (rst_n),
        .bus        (bus)
    );

    always #5 clk_in_100M = ~clk_in_100M;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called on a falling edge: raises mon_in now, holds it for p/2 cycles,
    // drops it and returns p falling edges later, so consecutive calls give
    // rises exactly p cycles apart. The rise is reported 2 edges after it is
    // sampled, i.e. visible on the 3rd falling edge.
    task automatic pulse(input int p, input bit ev, input int eper, input bit elock);
        bus.mon_in = 1'b1;
        for (int i = 1; i <= p; i++) begin
            @(negedge clk_in_100M);
            if (i == 2) begin
                check_val("valid_early", 32'(bus.period_valid), 0);
                check_val("fault_hold", 32'(bus.fault), 32'(fault_exp));
                check_val("locked_hold", 32'(bus.locked), 32'(lock_exp));
            end
            if (i == 3) begin
                check_val("valid", 32'(bus.period_valid), 32'(ev));
                if (ev)
                    check_val("period", 32'(bus.period), 32'(eper));
                check_val("locked", 32'(bus.locked), 32'(elock));
                check_val("fault_clr", 32'(bus.fault), 0);
                lock_exp  = elock;
                fault_exp = 1'b0;
            end
            if (i == 4)
                check_val("valid_pulse", 32'(bus.period_valid), 0);
            if (i == p / 2)
                bus.mon_in = 1'b0;
        end
    endtask

    initial begin
        bus.mon_in = 1'b0;
        #2 rst_n = 1'b0;

        // Reset held with mon_in toggling.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in_100M);
            bus.mon_in = ~bus.mon_in;
        end
        check_val("rst_period", 32'(bus.period), 0);
        check_val("rst_valid", 32'(bus.period_valid), 0);
        check_val("rst_locked", 32'(bus.locked), 0);
        check_val("rst_fault", 32'(bus.fault), 0);
        bus.mon_in = 1'b0;
        repeat (3) @(negedge clk_in_100M);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_in_100M);

        // Steady wave: first report at rise 2, lock at rise 5.
        pulse(100, 0, 0, 0);
        pulse(100, 1, 100, 0);
        pulse(100, 1, 100, 0);
        pulse(100, 1, 100, 0);
        pulse(100, 1, 100, 1);

        // Tolerance boundaries while locked.
        pulse(90, 1, 100, 1);
        pulse(110, 1, 90, 1);
        pulse(111, 1, 110, 1);
        pulse(100, 1, 111, 0);
        pulse(100, 1, 100, 0);
        pulse(100, 1, 100, 0);
        pulse(100, 1, 100, 0);
        pulse(100, 1, 100, 1);

        // Stop toggling: fault exactly TIMEOUT cycles after the last rise registered.
        pulse(202, 1, 100, 1);
        check_val("pre_fault", 32'(bus.fault), 0);
        check_val("pre_fault_lock", 32'(bus.locked), 1);
        @(negedge clk_in_100M);
        check_val("fault_set", 32'(bus.fault), 1);
        check_val("fault_unlock", 32'(bus.locked), 0);
        fault_exp = 1'b1;
        lock_exp  = 1'b0;
        repeat (50) @(negedge clk_in_100M);
        check_val("fault_stays", 32'(bus.fault), 1);

        // Restart: first rise clears fault without a report.
        pulse(100, 0, 0, 0);
        pulse(100, 1, 100, 0);
        pulse(100, 1, 100, 0);
        pulse(100, 1, 100, 0);
        pulse(100, 1, 100, 1);

        // Reset 50 cycles into a locked period.
        bus.mon_in = 1'b1;
        repeat (50) @(negedge clk_in_100M);
        check_val("pre_rst_locked", 32'(bus.locked), 1);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_period", 32'(bus.period), 0);
        check_val("mid_rst_locked", 32'(bus.locked), 0);
        check_val("mid_rst_valid", 32'(bus.period_valid), 0);
        check_val("mid_rst_fault", 32'(bus.fault), 0);
        bus.mon_in = 1'b0;
        repeat (3) @(negedge clk_in_100M);
        rst_n = 1'b1;
        lock_exp  = 1'b0;
        fault_exp = 1'b0;
        repeat (2) @(negedge clk_in_100M);
        pulse(100, 0, 0, 0);
        pulse(100, 1, 100, 0);
        pulse(100, 1, 100, 0);
        pulse(100, 1, 100, 0);
        pulse(100, 1, 100, 1);

        // Rise coincident with cnt == TIMEOUT: reported, bad, no fault.
        pulse(200, 1, 100, 1);
        pulse(100, 1, 200, 0);

        // Lower bound: 89 is bad and restarts the good run.
        pulse(89, 1, 100, 0);
        pulse(100, 1, 89, 0);
        pulse(100, 1, 100, 0);
        pulse(100, 1, 100, 0);
        pulse(100, 1, 100, 0);
        pulse(100, 1, 100, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
